// File: rtl/aurora_link_supervisor.sv
// rtl/aurora_link_supervisor.sv - Aurora reset sequencer and link-up supervisor.
// Optional retry limit / FAULT state: define AURORA_RETRY_LIMIT_EN.
module aurora_link_supervisor #(
  parameter int PmaInitCycles      = 75_000_000,
  parameter int ResetPbHoldCycles  = 25_000_000,
  parameter int UpTimeoutCycles    = 100_000_000,
  parameter int LossDebounceCycles = 1024,
  parameter int MaxRetries         = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            gt_pll_lock,
  input  logic                            channel_up,
  input  logic                            lane_up,
  input  logic                            force_reset,
  output logic                            pma_init,
  output logic                            reset_pb,
  output logic                            link_ok,
  output logic                            fault,
  output logic [$clog2(MaxRetries+1)-1:0] retry_cnt,
  output logic [7:0]                      drop_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CntMax  = max2(max2(PmaInitCycles, ResetPbHoldCycles), UpTimeoutCycles);
  localparam int CntW    = $clog2(CntMax + 1);
  localparam int LossW   = $clog2(LossDebounceCycles + 1);
  localparam int RetryW  = $clog2(MaxRetries + 1);

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_PB_HOLD = 3'd1,
    ST_WAIT_UP = 3'd2,
    ST_UP      = 3'd3,
    ST_RETRY   = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t            state, next_state;
  logic [CntW-1:0]   cnt, load_val;
  logic              load, cnt_expired;
  logic [LossW-1:0]  loss_cnt;
  logic [2:0]        sync1, sync2;
  logic              stable;
  logic              pma_init_d, reset_pb_d, link_ok_d, fault_d;

  // Two-flop synchronizers for the asynchronous core status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= {gt_pll_lock, channel_up, lane_up};
      sync2 <= sync1;
    end
  end

  assign stable      = &sync2;
  assign cnt_expired = (cnt <= CntW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RESET:   if (!force_reset && cnt_expired) next_state = ST_PB_HOLD;
      ST_PB_HOLD: begin
        if (force_reset)      next_state = ST_RESET;
        else if (cnt_expired) next_state = ST_WAIT_UP;
      end
      ST_WAIT_UP: begin
        if (force_reset)      next_state = ST_RESET;
        else if (stable)      next_state = ST_UP;
        else if (cnt_expired) next_state = ST_RETRY;
      end
      ST_UP: begin
        if (force_reset) next_state = ST_RESET;
        else if (!stable && loss_cnt == LossW'(LossDebounceCycles - 1)) next_state = ST_RETRY;
      end
      ST_RETRY: begin
`ifdef AURORA_RETRY_LIMIT_EN
        if (retry_cnt == RetryW'(MaxRetries)) next_state = ST_FAULT;
        else                                  next_state = ST_RESET;
`else
        next_state = ST_RESET;
`endif
      end
      ST_FAULT:   next_state = ST_FAULT;
      default:    next_state = ST_RESET;
    endcase
  end

  always_comb begin
    pma_init_d = 1'b0;
    reset_pb_d = 1'b0;
    link_ok_d  = 1'b0;
    fault_d    = 1'b0;
    case (next_state)
      ST_RESET:   begin pma_init_d = 1'b1; reset_pb_d = 1'b1; end
      ST_PB_HOLD: reset_pb_d = 1'b1;
      ST_UP:      link_ok_d = 1'b1;
      ST_FAULT: begin
        pma_init_d = 1'b1;
        reset_pb_d = 1'b1;
`ifdef AURORA_RETRY_LIMIT_EN
        fault_d    = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pma_init <= 1'b1;
      reset_pb <= 1'b1;
      link_ok  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      pma_init <= pma_init_d;
      reset_pb <= reset_pb_d;
      link_ok  <= link_ok_d;
      fault    <= fault_d;
    end
  end

  // Shared interval counter: reloaded on each state entry and on force_reset in RESET.
  assign load = (next_state != state) || (state == ST_RESET && force_reset);

  always_comb begin
    load_val = '0;
    case (next_state)
      ST_RESET:   load_val = CntW'(PmaInitCycles);
      ST_PB_HOLD: load_val = CntW'(ResetPbHoldCycles);
      ST_WAIT_UP: load_val = CntW'(UpTimeoutCycles);
      default:    load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= CntW'(PmaInitCycles);
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt  <= '0;
      retry_cnt <= '0;
      drop_cnt  <= 8'd0;
    end else begin
      if (state == ST_UP && next_state == ST_UP && !stable) loss_cnt <= loss_cnt + 1'b1;
      else                                                   loss_cnt <= '0;

      if (state != ST_UP && next_state == ST_UP)
        retry_cnt <= '0;
      else if (state != ST_RETRY && next_state == ST_RETRY && retry_cnt != {RetryW{1'b1}})
        retry_cnt <= retry_cnt + 1'b1;

      if (state == ST_UP && next_state == ST_RETRY && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// tb/tb_aurora_link_supervisor.sv - self-checking bench for aurora_link_supervisor.
module tb_aurora_link_supervisor;

  localparam int PmaN   = 100;
  localparam int PbN    = 50;
  localparam int UpN    = 1000;
  localparam int LossN  = 8;
  localparam int RetryN = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gt_pll_lock = 1'b0, channel_up = 1'b0, lane_up = 1'b0, force_reset = 1'b0;
  logic       pma_init, reset_pb, link_ok, fault;
  logic [1:0] retry_cnt;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_drop = 0;
  int exp_retry = 0;

  aurora_link_supervisor #(
    .PmaInitCycles(PmaN), .ResetPbHoldCycles(PbN), .UpTimeoutCycles(UpN),
    .LossDebounceCycles(LossN), .MaxRetries(RetryN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gt_pll_lock(gt_pll_lock), .channel_up(channel_up),
    .lane_up(lane_up), .force_reset(force_reset), .pma_init(pma_init), .reset_pb(reset_pb),
    .link_ok(link_ok), .fault(fault), .retry_cnt(retry_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // reset_pb must never be low while pma_init is high.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (reset_pb === 1'b0 && pma_init === 1'b1) begin
        errors++;
        $display("FAIL order_invariant: pma_init=%b reset_pb=%b, required reset_pb high while pma_init high", pma_init, reset_pb);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic start_from_reset(input logic g, input logic c, input logic l);
    rst_n = 1'b0;
    force_reset = 1'b0;
    gt_pll_lock = g; channel_up = c; lane_up = l;
    step(3);
    rst_n = 1'b1;
    cyc = 0;
    exp_drop = 0;
    exp_retry = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    force_reset = 1'b0;
    gt_pll_lock = 1'b1; channel_up = 1'b1; lane_up = 1'b1;
    step(3);
    checks++;
    if ({pma_init, reset_pb, link_ok, fault} !== 4'b1100 || retry_cnt !== 2'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: pma/pb/ok/fault=%b%b%b%b retry=%0d drop=%0d, required 1100 0 0",
               pma_init, reset_pb, link_ok, fault, retry_cnt, drop_cnt);
    end
    rst_n = 1'b1;
    cyc = 0;
    step(PmaN - 1);
    checks++;
    if (pma_init !== 1'b1) begin errors++; $display("FAIL pma_hold: cycle %0d pma_init=%b, required 1", cyc, pma_init); end
    step(1);
    checks++;
    if (pma_init !== 1'b0 || reset_pb !== 1'b1) begin
      errors++; $display("FAIL pma_fall: cycle %0d pma_init=%b reset_pb=%b, required 0 1", cyc, pma_init, reset_pb);
    end
    step(PbN - 1);
    checks++;
    if (reset_pb !== 1'b1) begin errors++; $display("FAIL pb_hold: cycle %0d reset_pb=%b, required 1", cyc, reset_pb); end
    step(1);
    checks++;
    if (reset_pb !== 1'b0) begin errors++; $display("FAIL pb_fall: cycle %0d reset_pb=%b, required 0", cyc, reset_pb); end
    step(3);
    checks++;
    if (link_ok !== 1'b1 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL link_up: cycle %0d link_ok=%b retry=%0d, required 1 0", cyc, link_ok, retry_cnt);
    end
  endtask

  // Lane drops of random length while UP; drops of LossN or more cycles must retrain the link.
  task automatic test_loss;
    int len;
    logic exp_ok;
    for (int it = 0; it < 8; it++) begin
      len = (it == 0) ? LossN - 1 : (it == 1) ? LossN : int'($urandom_range(1, 14));
      lane_up = 1'b0;
      for (int c = 1; c <= 14; c++) begin
        step(1);
        exp_ok = (len >= LossN && c >= LossN + 2) ? 1'b0 : 1'b1;
        checks++;
        if (link_ok !== exp_ok) begin
          errors++; $display("FAIL loss_link_ok: drop len %0d cycle %0d link_ok=%b, required %b", len, c, link_ok, exp_ok);
        end
        if (len >= LossN && c == LossN + 2) begin
          exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
          exp_retry = (exp_retry < 3) ? exp_retry + 1 : 3;
        end
        if (len >= LossN && c == LossN + 3) begin
          checks++;
          if (pma_init !== 1'b1 || reset_pb !== 1'b1 || retry_cnt !== 2'(exp_retry)) begin
            errors++; $display("FAIL loss_reset_entry: pma=%b pb=%b retry=%0d, required 1 1 %0d",
                               pma_init, reset_pb, retry_cnt, exp_retry);
          end
        end
        if (c == len) lane_up = 1'b1;
      end
      checks++;
      if (drop_cnt !== 8'(exp_drop)) begin
        errors++; $display("FAIL drop_cnt: drop len %0d drop_cnt=%0d, required %0d", len, drop_cnt, exp_drop);
      end
      if (len >= LossN) begin
        // RESET entered at cycle LossN+3; UP follows RESET and PB_HOLD by one cycle.
        step(LossN + 3 + PmaN + PbN - 14);
        checks++;
        if (link_ok !== 1'b0) begin errors++; $display("FAIL relink_early: link_ok=%b, required 0", link_ok); end
        step(1);
        exp_retry = 0;
        checks++;
        if (link_ok !== 1'b1 || retry_cnt !== 2'(exp_retry)) begin
          errors++; $display("FAIL relink: link_ok=%b retry=%0d, required 1 0", link_ok, retry_cnt);
        end
      end
    end
  endtask

  task automatic test_force;
    force_reset = 1'b1;
    step(1);
    force_reset = 1'b0;
    checks++;
    if (pma_init !== 1'b1 || reset_pb !== 1'b1 || link_ok !== 1'b0 ||
        retry_cnt !== 2'(exp_retry) || drop_cnt !== 8'(exp_drop)) begin
      errors++; $display("FAIL force_up: pma=%b pb=%b ok=%b retry=%0d drop=%0d, required 1 1 0 %0d %0d",
                         pma_init, reset_pb, link_ok, retry_cnt, drop_cnt, exp_retry, exp_drop);
    end
    step(49);
    force_reset = 1'b1;
    step(1);
    force_reset = 1'b0;
    step(PmaN - 1);
    checks++;
    if (pma_init !== 1'b1) begin errors++; $display("FAIL force_restart_hold: pma_init=%b, required 1", pma_init); end
    step(1);
    checks++;
    if (pma_init !== 1'b0 || reset_pb !== 1'b1) begin
      errors++; $display("FAIL force_restart_fall: pma=%b pb=%b, required 0 1", pma_init, reset_pb);
    end
  endtask

  task automatic test_async_reset;
    step(20);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pma_init, reset_pb, link_ok, fault} !== 4'b1100 || retry_cnt !== 2'd0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL async_reset: pma/pb/ok/fault=%b%b%b%b retry=%0d drop=%0d, required 1100 0 0",
                         pma_init, reset_pb, link_ok, fault, retry_cnt, drop_cnt);
    end
  endtask

  // channel_up held low: each attempt is RESET + PB_HOLD + UpN cycles of WAIT_UP + one RETRY cycle.
  task automatic test_timeout;
    int retry_at;
    int last_k;
    logic exp_fault;
`ifdef AURORA_RETRY_LIMIT_EN
    last_k = RetryN;
`else
    last_k = RetryN + 1;
`endif
    start_from_reset(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= last_k; k++) begin
      retry_at = PmaN + PbN + UpN + (k - 1) * (PmaN + PbN + UpN + 1);
      step(retry_at - 1 - cyc);
      checks++;
      if (pma_init !== 1'b0 || reset_pb !== 1'b0 || link_ok !== 1'b0) begin
        errors++; $display("FAIL wait_up_%0d: pma=%b pb=%b ok=%b, required 0 0 0", k, pma_init, reset_pb, link_ok);
      end
      step(1);
      exp_retry = (k < 3) ? k : 3;
      checks++;
      if (retry_cnt !== 2'(exp_retry) || pma_init !== 1'b0) begin
        errors++; $display("FAIL retry_%0d: cycle %0d retry=%0d pma=%b, required %0d 0", k, cyc, retry_cnt, pma_init, exp_retry);
      end
      step(1);
`ifdef AURORA_RETRY_LIMIT_EN
      exp_fault = (k == RetryN);
`else
      exp_fault = 1'b0;
`endif
      checks++;
      if (pma_init !== 1'b1 || reset_pb !== 1'b1 || fault !== exp_fault) begin
        errors++; $display("FAIL after_retry_%0d: pma=%b pb=%b fault=%b, required 1 1 %b", k, pma_init, reset_pb, fault, exp_fault);
      end
    end
`ifdef AURORA_RETRY_LIMIT_EN
    step(300);
    channel_up = 1'b1;
    step(300);
    checks++;
    if (fault !== 1'b1 || pma_init !== 1'b1 || reset_pb !== 1'b1 || link_ok !== 1'b0) begin
      errors++; $display("FAIL fault_sticky: fault=%b pma=%b pb=%b ok=%b, required 1 1 1 0", fault, pma_init, reset_pb, link_ok);
    end
    start_from_reset(1'b1, 1'b1, 1'b1);
    step(PmaN + PbN + 1);
    checks++;
    if (fault !== 1'b0 || link_ok !== 1'b1) begin
      errors++; $display("FAIL fault_recover: fault=%b ok=%b, required 0 1", fault, link_ok);
    end
`else
    checks++;
    if (fault !== 1'b0 || retry_cnt !== 2'd3) begin
      errors++; $display("FAIL retry_saturate: fault=%b retry=%0d, required 0 3", fault, retry_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_loss();
    test_force();
    test_async_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_link_supervisor.md
# aurora_link_supervisor

Supervises the Aurora link after the clock/reset generator: drives `pma_init` and `reset_pb` in the vendor-mandated order and watches `gt_pll_lock`/`channel_up`/`lane_up`. It re-runs the reset sequence on link-up timeout or on sustained link loss. It publishes a qualified `link_ok` to the peripheral-reset logic. Runs on the 50 MHz Aurora init clock.

## Interface
- `PmaInitCycles`, 75_000_000: cycles `pma_init` is held high per reset sequence (1.5 s at 50 MHz).
- `ResetPbHoldCycles`, 25_000_000: cycles `reset_pb` stays high after `pma_init` falls.
- `UpTimeoutCycles`, 100_000_000: maximum cycles in WAIT_UP before a retry.
- `LossDebounceCycles`, 1024: consecutive not-stable cycles in UP that count as link loss.
- `MaxRetries`, 8: consecutive failed attempts before FAULT (only with the retry limit compiled in).
- `clk`  in  1  Aurora init clock. One clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `gt_pll_lock`, `channel_up`, `lane_up`  in  1 each  async status bits from the Aurora core.
- `force_reset`  in  1  one-cycle request to restart the sequence.
- `pma_init`  out  1  Aurora PMA init.
- `reset_pb`  out  1  Aurora reset pushbutton.
- `link_ok`  out  1  link qualified up.
- `fault`  out  1  retry limit exhausted.
- `retry_cnt`  out  $clog2(MaxRetries+1)  consecutive failed attempts.
- `drop_cnt`  out  8  saturating count of UP-to-RETRY link drops.

## Operation
- Status inputs pass through 2-flop synchronizers each. `stable` = AND of the three synchronized bits.
- One shared down-counter, wide enough for the largest parameter. It is loaded on every state entry.
- States:
  - RESET: `pma_init=1`, `reset_pb=1`. Lasts PmaInitCycles, then goes to PB_HOLD.
  - PB_HOLD: `pma_init=0`, `reset_pb=1`. Lasts ResetPbHoldCycles, then goes to WAIT_UP.
  - WAIT_UP: both outputs 0.
    - `stable` goes to UP.
    - Counter expiry (UpTimeoutCycles) goes to RETRY.
    - `stable` wins if both occur in the same cycle.
  - UP: `link_ok=1`. `retry_cnt` clears on entry.
    - Each `!stable` cycle increments the loss counter. Any `stable` cycle clears it.
    - The loss counter reaching LossDebounceCycles goes to RETRY and increments `drop_cnt` (saturates at 255).
  - RETRY: lasts one cycle.
    - `retry_cnt` increments, saturating at its maximum.
    - Then goes to RESET, or to FAULT (see Configuration).
  - FAULT: `pma_init=1`, `reset_pb=1`, `fault=1`. Only `rst_n` exits this state.
- `force_reset` in PB_HOLD, WAIT_UP or UP jumps to RESET without touching `retry_cnt` or `drop_cnt`.
- In RESET, `force_reset` restarts the RESET count. In RETRY and FAULT it is ignored.
- `force_reset` has priority over every other transition in the same cycle.
- `reset_pb` never falls before `pma_init`. `pma_init` never rises while `reset_pb` is low, except at the RETRY→RESET or force entry, where both rise on the same edge.

## Timing
- Reset values:
  - State RESET, with the counter loaded to PmaInitCycles.
  - `pma_init=1`, `reset_pb=1`, `link_ok=0`, `fault=0`, `retry_cnt=0`, `drop_cnt=0`.
- All outputs are registered and change on the same edge as the state register.
- From the first `clk` edge after `rst_n` rises:
  - `pma_init` stays high for exactly PmaInitCycles cycles.
  - `reset_pb` stays high for exactly PmaInitCycles + ResetPbHoldCycles cycles.
- Input-to-state latency is 2 synchronizer cycles plus 1 cycle.
  - `link_ok` rises 3 cycles after `stable` asserts at the pins.
  - After a loss, `link_ok` falls LossDebounceCycles + 2 cycles after `stable` drops at the pins, on the edge entering RETRY.
- RESET re-entry happens exactly 1 cycle after RETRY.
- Asserting `rst_n` mid-sequence forces the reset values immediately (asynchronous).

## Configuration
- `AURORA_RETRY_LIMIT_EN` defined:
  - RETRY goes to FAULT when the incremented `retry_cnt` equals MaxRetries; otherwise it goes to RESET.
- `AURORA_RETRY_LIMIT_EN` undefined:
  - RETRY always goes to RESET.
  - FAULT is unreachable and `fault` is tied to 0.
  - `retry_cnt` still counts and saturates.

## Test plan
Bench parameters: PmaInitCycles=100, ResetPbHoldCycles=50, UpTimeoutCycles=1000, LossDebounceCycles=8, MaxRetries=3.
- Release `rst_n` with all status bits high:
  - `pma_init` falls on cycle 100 and `reset_pb` falls on cycle 150.
  - `link_ok` rises by cycle 153. `retry_cnt=0`.
- Drop `lane_up` for 7 cycles while in UP, then restore it: `link_ok` stays 1 and `drop_cnt=0`.
- Drop `lane_up` for 8 or more cycles while in UP:
  - `link_ok` falls 10 cycles after the drop.
  - `drop_cnt=1`.
  - `pma_init` and `reset_pb` rise 1 cycle later.
- Hold `channel_up=0` with `AURORA_RETRY_LIMIT_EN` defined:
  - Timeouts at 1000 cycles each.
  - `fault=1` after the 3rd retry; `pma_init` and `reset_pb` stay high.
  - Only `rst_n` recovers the block.
- Same stimulus with `AURORA_RETRY_LIMIT_EN` undefined: retries continue indefinitely, `retry_cnt` saturates at 3, and `fault` stays 0.
- Pulse `force_reset` in UP: the next cycle is RESET with `pma_init=1`, and `retry_cnt` and `drop_cnt` are unchanged.
- Assert `rst_n` low mid-PB_HOLD: outputs return to their reset values immediately.
